datamem_responder: RTL and testbench
====================================

DATAMEM_RESPONDER -- requirements
Module: datamem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, log2 of memory depth in WIDTH-bit words.
REQ-003 SHALL have parameter LATENCY, default 2, access cycles from acceptance to response; legal range 1..15.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports clk_in and rst_in.
REQ-005 clk_in  input  1  clock; all state changes on rising edge.
REQ-006 rst_in  input  1  asynchronous reset; asserted when low.
REQ-007 req_valid_in  input  1  initiator presents a request.
REQ-008 req_ready_out  output  1  responder can accept a request.
REQ-009 req_we_in  input  1  1 = store, 0 = load.
REQ-010 req_addr_mode_in  input  1  0 = word access, 1 = byte access.
REQ-011 req_addr_in  input  WIDTH  byte address.
REQ-012 req_wdata_in  input  WIDTH  store data; byte stores use bits [7:0].
REQ-013 rsp_valid_out  output  1  response available.
REQ-014 rsp_ready_in  input  1  initiator accepts the response.
REQ-015 rsp_rdata_out  output  WIDTH  load data; 0 for stores and errors.
REQ-016 rsp_err_out  output  1  request faulted: misaligned word access or out-of-range address.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; req_ready_out = 1 only in IDLE; rsp_valid_out = 1 only in RESP.
REQ-018 SHALL accept a request on a rising edge with req_valid_in && req_ready_out, latching we, mode, addr, wdata, loading counter with LATENCY-1, entering WAIT.
REQ-019 In WAIT, SHALL decrement counter each edge while nonzero; on the edge where counter == 0, SHALL perform the access, register response, and enter RESP.
REQ-020 rsp_valid_out SHALL rise exactly LATENCY edges after the acceptance edge; req inputs SHALL be ignored outside IDLE.
REQ-021 In RESP, SHALL hold rsp_rdata_out and rsp_err_out stable until the edge with rsp_ready_in = 1, then enter IDLE; next request may be accepted on the following edge.
REQ-022 Memory SHALL be 2**DEPTH_LOG2 words, little-endian; word index = addr[DEPTH_LOG2+1:2], byte lane = addr[1:0].
REQ-023 Word load SHALL return the full word; byte load SHALL return the selected byte zero-extended in [7:0].
REQ-024 Word store SHALL write all 4 bytes; byte store SHALL write only the selected lane from wdata[7:0], other lanes unchanged.
REQ-025 Error when addr >= 4*2**DEPTH_LOG2, or word mode with addr[1:0] != 0: no memory write, rsp_rdata_out = 0, rsp_err_out = 1.
REQ-026 Stores SHALL produce a response (rdata 0, err per REQ-025) like loads.
REQ-027 A load after a store to the same address SHALL observe the stored data.

Reset
REQ-028 While rst_in = 0: state IDLE, counter 0, req_ready_out = 1, rsp_valid_out = 0, rsp_rdata_out = 0, rsp_err_out = 0.
REQ-029 Reset in WAIT or RESP SHALL abort the transaction; a store not yet performed SHALL NOT write; memory contents are not reset.

Verification
REQ-030 LATENCY=2: word store 0xDEADBEEF to 0x10, then word load 0x10 -> rsp_valid_out high 2 edges after each acceptance; load rdata 0xDEADBEEF, err 0.
REQ-031 Byte store 0xAA to 0x11 over 0xDEADBEEF at 0x10, then word load 0x10 -> 0xDEADAAEF; byte load 0x13 -> 0x000000DE.
REQ-032 Word load from 0x12 and byte load from 4*2**DEPTH_LOG2 -> err 1, rdata 0; store to 0x12 -> err 1, word at 0x10 unchanged.
REQ-033 Hold rsp_ready_in low 5 cycles in RESP -> rsp_valid_out, rdata, err stable; req_ready_out 0; new req_valid_in ignored until after the rsp_ready_in edge.
REQ-034 Assert rst_in low during WAIT of a word store 0x12345678 to 0x20 -> outputs at reset values immediately; subsequent load 0x20 returns prior contents.
REQ-035 LATENCY=1: back-to-back requests with rsp_ready_in tied 1 -> one response per 3 cycles, responses in request order.

Source files
------------

// File: rtl/datamem_responder.sv
// Single-port data memory behind a valid/ready request/response handshake.
// Each request is answered after a fixed access latency. Misaligned word accesses and out-of-range addresses fault.
module datamem_responder #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic             req_we_in,
  input  logic             req_addr_mode_in,
  input  logic [WIDTH-1:0] req_addr_in,
  input  logic [WIDTH-1:0] req_wdata_in,
  output logic             rsp_valid_out,
  input  logic             rsp_ready_in,
  output logic [WIDTH-1:0] rsp_rdata_out,
  output logic             rsp_err_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic                  r_we, r_mode;
  logic [WIDTH-1:0]      r_addr, r_wdata, r_rdata;
  logic                  r_err;
  logic [WIDTH-1:0]      r_mem [DEPTH];

  logic                  w_accept, w_access, w_oor, w_misal, w_err;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_lane;
  logic [WIDTH-1:0]      w_word, w_load;
  logic [7:0]            w_byte;

  assign w_accept = (r_state == IDLE) && req_valid_in;
  assign w_access = (r_state == WAIT) && (r_cnt == '0);
  assign w_idx    = r_addr[DEPTH_LOG2+1:2];
  assign w_lane   = r_addr[1:0];

  // Any address bit above the byte span of the array means out of range.
  generate
    if (WIDTH > DEPTH_LOG2 + 2) begin : g_oor
      assign w_oor = |r_addr[WIDTH-1:DEPTH_LOG2+2];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  assign w_misal = !r_mode && (w_lane != 2'b00);
  assign w_err   = w_oor || w_misal;
  assign w_word  = r_mem[w_idx];
  assign w_byte  = w_word[{w_lane, 3'b000} +: 8];
  assign w_load  = r_mode ? {{(WIDTH-8){1'b0}}, w_byte} : w_word;

  // Memory contents survive reset; a faulted store never writes.
  always_ff @(posedge clk_in) begin
    if (w_access && r_we && !w_err) begin
      if (r_mode) r_mem[w_idx][{w_lane, 3'b000} +: 8] <= r_wdata[7:0];
      else        r_mem[w_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_mode  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= req_we_in;
        r_mode  <= req_addr_mode_in;
        r_addr  <= req_addr_in;
        r_wdata <= req_wdata_in;
        r_cnt   <= CW'(LATENCY - 1);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_access) begin
        r_rdata <= (w_err || r_we) ? '0 : w_load;
        r_err   <= w_err;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    req_ready_out = 1'b0;
    rsp_valid_out = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) w_state_nxt = WAIT;
      end
      WAIT: if (r_cnt == '0) w_state_nxt = RESP;
      RESP: begin
        rsp_valid_out = 1'b1;
        if (rsp_ready_in) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rsp_rdata_out = r_rdata;
  assign rsp_err_out   = r_err;

endmodule

// File: tb/tb_datamem_responder.sv
// Scoreboard bench for datamem_responder: a LATENCY=2 instance for functional scenarios
// and a LATENCY=1 instance for back-to-back throughput and ordering.
module tb_datamem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_mode, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        b_valid, b_ready, b_we, b_mode, b_rvalid, b_rerr;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int          n_chk = 0, n_fail = 0, cyc = 0;
  rsp_t        exp_q[$], exp_q1[$];
  logic [31:0] mdl [int];
  logic [31:0] last_rdata;

  datamem_responder #(.WIDTH(32), .DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk_in(clk), .rst_in(rst_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready), .req_we_in(req_we),
    .req_addr_mode_in(req_mode), .req_addr_in(req_addr), .req_wdata_in(req_wdata),
    .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready),
    .rsp_rdata_out(rsp_rdata), .rsp_err_out(rsp_err)
  );

  datamem_responder #(.WIDTH(32), .DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk_in(clk), .rst_in(rst_n),
    .req_valid_in(b_valid), .req_ready_out(b_ready), .req_we_in(b_we),
    .req_addr_mode_in(b_mode), .req_addr_in(b_addr), .req_wdata_in(b_wdata),
    .rsp_valid_out(b_rvalid), .rsp_ready_in(1'b1),
    .rsp_rdata_out(b_rdata), .rsp_err_out(b_rerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: byte-addressed little-endian memory of 1024 words.
  task automatic model_access(input logic we, input logic mode, input logic [31:0] addr,
                              input logic [31:0] wdata, output rsp_t e);
    int unsigned idx, lane;
    logic [31:0] w;
    idx  = addr >> 2;
    lane = addr & 32'h3;
    e.err   = (addr >= 32'h1000) || (!mode && lane != 0);
    e.rdata = 32'h0;
    if (!e.err) begin
      w = mdl.exists(idx) ? mdl[idx] : 32'h0;
      if (we) begin
        if (mode) w[8*lane +: 8] = wdata[7:0];
        else      w = wdata;
        mdl[idx] = w;
      end else begin
        e.rdata = mode ? {24'h0, w[8*lane +: 8]} : w;
      end
    end
  endtask

  // One transaction on the LATENCY=2 instance; during 'hold' cycles a stray store is offered.
  task automatic do_req(input logic we, input logic mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    rsp_t e;
    int   n;
    logic [31:0] h_rdata;
    logic        h_err;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata;
    n_chk++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL accept_ready: got %b want 1", req_ready);
    end
    model_access(we, mode, addr, wdata, e);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (rsp_valid !== 1'b1 || n != 2) begin
      n_fail++; $display("FAIL latency: got %0d edges (valid %b) want 2", n, rsp_valid);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '{32'hx, 1'bx};
    n_chk++;
    if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
      n_fail++;
      $display("FAIL rsp_data addr=%h: got rdata %h err %b want rdata %h err %b",
               addr, rsp_rdata, rsp_err, e.rdata, e.err);
    end
    last_rdata = rsp_rdata;
    h_rdata = rsp_rdata;
    h_err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_mode = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== h_rdata || rsp_err !== h_err || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable cyc %0d: valid %b rdata %h err %b ready %b want 1 %h %b 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, h_rdata, h_err);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_chk++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL release: valid %b ready %b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_chk++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ready %b valid %b rdata %h err %b want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_word;
    do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 0);
    n_chk++;
    if (last_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL word_load: got %h want deadbeef", last_rdata);
    end
  endtask

  task automatic test_byte;
    do_req(1'b1, 1'b1, 32'h11, 32'h123456AA, 0);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 0);
    n_chk++;
    if (last_rdata !== 32'hDEADAAEF) begin
      n_fail++; $display("FAIL byte_merge: got %h want deadaaef", last_rdata);
    end
    do_req(1'b0, 1'b1, 32'h13, 32'h0, 0);
    n_chk++;
    if (last_rdata !== 32'h000000DE) begin
      n_fail++; $display("FAIL byte_load: got %h want 000000de", last_rdata);
    end
  endtask

  task automatic test_errors;
    do_req(1'b0, 1'b0, 32'h12, 32'h0, 0);
    do_req(1'b0, 1'b1, 32'h1000, 32'h0, 0);
    do_req(1'b1, 1'b0, 32'h12, 32'h55555555, 0);
    do_req(1'b1, 1'b0, 32'h1010, 32'h77777777, 0);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 0);
    n_chk++;
    if (last_rdata !== 32'hDEADAAEF) begin
      n_fail++; $display("FAIL err_nowrite: got %h want deadaaef", last_rdata);
    end
    // Top of the array is still in range.
    do_req(1'b1, 1'b0, 32'hFFC, 32'h0BADF00D, 0);
    do_req(1'b1, 1'b1, 32'hFFF, 32'h000000C3, 0);
    do_req(1'b0, 1'b0, 32'hFFC, 32'h0, 0);
    do_req(1'b0, 1'b1, 32'hFFE, 32'h0, 0);
  endtask

  task automatic test_hold;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 5);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 0);
  endtask

  task automatic test_reset_abort;
    do_req(1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 0);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_mode = 1'b0; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: ready %b valid %b rdata %h err %b want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 0);
    n_chk++;
    if (last_rdata !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL abort_nowrite: got %h want cafef00d", last_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int   got, last_cyc, k;
    rsp_t e;
    got = 0;
    last_cyc = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          b_valid = 1'b1;
          b_we    = (i < 4);
          b_mode  = 1'b0;
          b_addr  = 32'h100 + 32'(4 * (i % 4));
          b_wdata = 32'hA0000000 + 32'(i);
          k = 0;
          while (b_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
          end
          @(posedge clk);
          e.err   = 1'b0;
          e.rdata = (i < 4) ? 32'h0 : 32'hA0000000 + 32'(i - 4);
          exp_q1.push_back(e);
        end
        @(negedge clk);
        b_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 200 && got < 8; t++) begin
          @(negedge clk);
          if (b_rvalid === 1'b1) begin
            e = (exp_q1.size() > 0) ? exp_q1.pop_front() : '{32'hx, 1'bx};
            n_chk++;
            if (b_rdata !== e.rdata || b_rerr !== e.err) begin
              n_fail++;
              $display("FAIL b2b_order rsp %0d: got %h err %b want %h err %b",
                       got, b_rdata, b_rerr, e.rdata, e.err);
            end
            if (got > 0) begin
              n_chk++;
              if (cyc - last_cyc != 3) begin
                n_fail++; $display("FAIL b2b_rate rsp %0d: got %0d cycles want 3", got, cyc - last_cyc);
              end
            end
            last_cyc = cyc;
            got++;
          end
        end
      end
    join
    n_chk++;
    if (got != 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d want 8", got);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_mode = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    b_valid = 1'b0; b_we = 1'b0; b_mode = 1'b0; b_addr = '0; b_wdata = '0;
    last_rdata = '0;
    test_reset;
    test_word;
    test_byte;
    test_errors;
    test_hold;
    test_reset_abort;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
